// File: rtl/mat_mult_engine.sv
// mat_mult_engine: 6x6 fixed-point matrix multiplier; one result row per cycle through a 2-stage pipeline.
// Build option: define MAT_MULT_SATURATE_EN to clamp results to the WIDTH-bit range instead of wrapping.
module mat_mult_engine #(
  parameter int WIDTH = 27,
  parameter int FRAC  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [5:0][5:0][WIDTH-1:0]   dataa,
  input  logic [5:0][5:0][WIDTH-1:0]   datab,
  output logic [5:0][5:0][WIDTH-1:0]   result,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = 2*WIDTH;
  localparam int SW = 2*WIDTH + 3;
`ifdef MAT_MULT_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                        state_q;
  logic [2:0]                    row_q;
  logic                          busy_q;
  logic                          done_q;

  logic [5:0][5:0][WIDTH-1:0]    snap_a_q, snap_a_d;
  logic [5:0][5:0][WIDTH-1:0]    snap_b_q, snap_b_d;
  logic [5:0][WIDTH-1:0]         arow;

  logic [5:0][5:0][PW-1:0]       prod_p1_q, prod_p1_d;
  logic [2:0]                    row_p1_q, row_p1_d;
  logic                          vld_p1_q, vld_p1_d;

  logic [5:0][PW-1:0]            col;
  logic signed [SW-1:0]          sum_p2;
  logic [5:0][5:0][WIDTH-1:0]    result_q, result_d;

  function automatic logic [PW-1:0] mul(input logic signed [WIDTH-1:0] x,
                                        input logic signed [WIDTH-1:0] y);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = x;
    ye = y;
    return xe * ye;
  endfunction

  function automatic logic signed [SW-1:0] col_sum(input logic [5:0][PW-1:0] p);
    logic signed [SW-1:0] acc;
    logic signed [PW-1:0] t;
    acc = '0;
    for (int k = 0; k < 6; k++) begin
      t   = p[k];
      acc = acc + SW'(t);
    end
    return acc;
  endfunction

  // Value fits WIDTH bits only when every bit above the WIDTH-1 sign position matches the sign.
  function automatic logic [WIDTH-1:0] reduce(input logic signed [SW-1:0] v);
    logic ovf;
    logic unf;
    ovf = !v[SW-1] && (|v[SW-2:WIDTH-1]);
    unf =  v[SW-1] && !(&v[SW-2:WIDTH-1]);
    if (SAT_EN && ovf) return {1'b0, {(WIDTH-1){1'b1}}};
    if (SAT_EN && unf) return {1'b1, {(WIDTH-1){1'b0}}};
    return v[WIDTH-1:0];
  endfunction

  // Operand snapshot: taken only on an accepted start so later input changes cannot leak in.
  always_comb begin
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    if (state_q == IDLE && start) begin
      snap_a_d = dataa;
      snap_b_d = datab;
    end
  end

  // Stage 1 (p1): issue row row_q, register its 36 products.
  always_comb begin
    prod_p1_d = prod_p1_q;
    row_p1_d  = row_p1_q;
    vld_p1_d  = 1'b0;
    arow      = '0;
    for (int r = 0; r < 6; r++)
      if (row_q == 3'(r)) arow = snap_a_q[r];
    if (state_q == RUN) begin
      vld_p1_d = 1'b1;
      row_p1_d = row_q;
      for (int k = 0; k < 6; k++)
        for (int c = 0; c < 6; c++)
          prod_p1_d[k][c] = mul(arow[k], snap_b_q[k][c]);
    end
  end

  // Stage 2 (p2): column sums, floor shift by FRAC, reduce and write the result row.
  always_comb begin
    result_d = result_q;
    col      = '0;
    sum_p2   = '0;
    if (vld_p1_q) begin
      for (int c = 0; c < 6; c++) begin
        for (int k = 0; k < 6; k++) col[k] = prod_p1_q[k][c];
        sum_p2 = col_sum(col) >>> FRAC;
        for (int r = 0; r < 6; r++)
          if (row_p1_q == 3'(r)) result_d[r][c] = reduce(sum_p2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      prod_p1_q <= '0;
      row_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      result_q  <= '0;
    end else if (en) begin
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      prod_p1_q <= prod_p1_d;
      row_p1_q  <= row_p1_d;
      vld_p1_q  <= vld_p1_d;
      result_q  <= result_d;
    end
  end

  // Control FSM: DRAIN waits for the last row to leave stage 2 before signalling done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (row_q == 3'd5) state_q <= DRAIN;
          else               row_q   <= row_q + 3'd1;
        end
        DRAIN: begin
          if (vld_p1_q && row_p1_q == 3'd5) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
